// File: rtl/pipe_stage_ctx_reg.sv
// Inter-stage {valid, inst, pc} register with a LIFO context stack that parks in-flight state across nested interrupts.
// One edge of latency, with stall/flush/save/restore priority control. No ready/valid backpressure; errors are sticky flags.
module pipe_stage_ctx_reg #(
  parameter int INST_W     = 32,
  parameter int PC_W       = 32,
  parameter int SAVE_DEPTH = 2,
  localparam int CNT_W     = $clog2(SAVE_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  input  logic [INST_W-1:0] in_inst,
  input  logic [PC_W-1:0]   in_pc,
  input  logic              stall,
  input  logic              flush,
  input  logic              int_save,
  input  logic              int_restore,
  input  logic              err_clr,
  output logic              out_valid,
  output logic [INST_W-1:0] out_inst,
  output logic [PC_W-1:0]   out_pc,
  output logic [CNT_W-1:0]  save_cnt,
  output logic              save_full,
  output logic              err_ovf,
  output logic              err_unf
);

  typedef struct packed {
    logic              valid;
    logic [INST_W-1:0] inst;
    logic [PC_W-1:0]   pc;
  } ctx_t;

  ctx_t             ctx_q, ctx_d, in_ctx, top_ctx;
  ctx_t             stack_q [SAVE_DEPTH];
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             full, push, ovf_set, unf_set;

  assign full   = (cnt_q == CNT_W'(SAVE_DEPTH));
  // Invalid entries are normalised to an all-zero bubble before they reach the register.
  assign in_ctx = in_valid ? '{valid: 1'b1, inst: in_inst, pc: in_pc} : '0;

  always_comb begin
    top_ctx = '0;
    for (int i = 0; i < SAVE_DEPTH; i++) begin
      if (cnt_q == CNT_W'(i + 1)) top_ctx = stack_q[i];
    end
  end

  always_comb begin
    ctx_d   = ctx_q;
    cnt_d   = cnt_q;
    push    = 1'b0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (flush) begin
      ctx_d = '0;
    end else if (int_save) begin
      ctx_d = '0;
      if (!full) begin
        push  = 1'b1;
        cnt_d = cnt_q + CNT_W'(1);
      end else begin
        ovf_set = 1'b1;
      end
    end else if (int_restore) begin
      // Restore beats stall so an interrupt return always completes.
      if (cnt_q != '0) begin
        ctx_d = top_ctx;
        cnt_d = cnt_q - CNT_W'(1);
      end else begin
        unf_set = 1'b1;
      end
    end else if (!stall) begin
      ctx_d = in_ctx;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctx_q   <= '0;
      cnt_q   <= '0;
      err_ovf <= 1'b0;
      err_unf <= 1'b0;
    end else begin
      ctx_q   <= ctx_d;
      cnt_q   <= cnt_d;
      err_ovf <= ovf_set | (err_ovf & ~err_clr);
      err_unf <= unf_set | (err_unf & ~err_clr);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SAVE_DEPTH; i++) stack_q[i] <= '0;
    end else if (push) begin
      for (int i = 0; i < SAVE_DEPTH; i++) begin
        if (cnt_q == CNT_W'(i)) stack_q[i] <= ctx_q;
      end
    end
  end

  assign out_valid = ctx_q.valid;
  assign out_inst  = ctx_q.inst;
  assign out_pc    = ctx_q.pc;
  assign save_cnt  = cnt_q;
  assign save_full = full;

endmodule

// File: tb/tb_pipe_stage_ctx_reg.sv
// Directed bench for pipe_stage_ctx_reg with hand-computed expectations.
module tb_pipe_stage_ctx_reg;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic [31:0] in_inst;
  logic [31:0] in_pc;
  logic        stall, flush, int_save, int_restore, err_clr;
  logic        out_valid;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic [1:0]  save_cnt;
  logic        save_full, err_ovf, err_unf;

  int total = 0;
  int bad   = 0;

  pipe_stage_ctx_reg #(.INST_W(32), .PC_W(32), .SAVE_DEPTH(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_inst(in_inst), .in_pc(in_pc),
    .stall(stall), .flush(flush), .int_save(int_save), .int_restore(int_restore),
    .err_clr(err_clr),
    .out_valid(out_valid), .out_inst(out_inst), .out_pc(out_pc),
    .save_cnt(save_cnt), .save_full(save_full), .err_ovf(err_ovf), .err_unf(err_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall = 0; flush = 0; int_save = 0; int_restore = 0; err_clr = 0;
  endtask

  task automatic load(input logic [31:0] pc, input logic [31:0] inst);
    idle();
    in_valid = 1; in_pc = pc; in_inst = inst;
    step();
  endtask

  task automatic do_save();
    idle();
    int_save = 1;
    step();
  endtask

  task automatic do_restore();
    idle();
    int_restore = 1;
    step();
  endtask

  initial begin
    // T1: reset with random inputs
    reset_n = 0;
    in_valid = 1'($urandom); in_inst = $urandom; in_pc = $urandom;
    stall = 1'($urandom); flush = 1'($urandom); int_save = 1'($urandom);
    int_restore = 1'($urandom); err_clr = 1'($urandom);
    step(); step();
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_inst", out_inst, 32'd0);
    chk("rst_pc", out_pc, 32'd0);
    chk("rst_cnt", {30'd0, save_cnt}, 32'd0);
    chk("rst_full", {31'd0, save_full}, 32'd0);
    chk("rst_errs", {30'd0, err_ovf, err_unf}, 32'd0);
    reset_n = 1;
    load(32'h100, 32'h2008_0005);
    chk("t1_valid", {31'd0, out_valid}, 32'd1);
    chk("t1_pc", out_pc, 32'h100);
    chk("t1_inst", out_inst, 32'h2008_0005);

    // T2: stall holds while inputs move, then flush beats stall
    idle(); stall = 1;
    for (int i = 0; i < 3; i++) begin
      in_pc = 32'h104 + 32'(4 * i); in_inst = 32'hDEAD_0000 + 32'(i);
      step();
      chk("t2_stall_pc", out_pc, 32'h100);
    end
    flush = 1;
    step();
    chk("t2_flush", {out_valid, out_inst[30:0]} | out_pc, 32'd0);
    idle(); in_valid = 0; in_pc = 32'h1234; in_inst = 32'h5678;
    step();
    chk("t2_inval_zero", out_pc | out_inst | {31'd0, out_valid}, 32'd0);

    // T3: save A, load B, save B, restore twice (LIFO)
    load(32'h200, 32'hAAAA_0001);
    do_save();
    chk("t3_save1_cnt", {30'd0, save_cnt}, 32'd1);
    chk("t3_save1_bubble", {31'd0, out_valid}, 32'd0);
    load(32'h300, 32'hBBBB_0002);
    chk("t3_loadB_pc", out_pc, 32'h300);
    do_save();
    chk("t3_save2_cnt", {30'd0, save_cnt}, 32'd2);
    chk("t3_full", {31'd0, save_full}, 32'd1);
    do_restore();
    chk("t3_rest1_pc", out_pc, 32'h300);
    chk("t3_rest1_inst", out_inst, 32'hBBBB_0002);
    chk("t3_rest1_cnt", {30'd0, save_cnt}, 32'd1);
    do_restore();
    chk("t3_rest2_pc", out_pc, 32'h200);
    chk("t3_rest2_valid", {31'd0, out_valid}, 32'd1);
    chk("t3_rest2_cnt", {30'd0, save_cnt}, 32'd0);

    // T4: overflow and underflow
    load(32'h200, 32'hAAAA_0001); do_save();
    load(32'h300, 32'hBBBB_0002); do_save();
    load(32'h400, 32'hCCCC_0003);
    do_save();
    chk("t4_ovf", {31'd0, err_ovf}, 32'd1);
    chk("t4_ovf_cnt", {30'd0, save_cnt}, 32'd2);
    chk("t4_ovf_bubble", {31'd0, out_valid} | out_pc, 32'd0);
    do_restore();
    chk("t4_intact_B", out_pc, 32'h300);
    do_restore();
    chk("t4_intact_A", out_pc, 32'h200);
    in_pc = 32'h999;
    do_restore();
    chk("t4_unf", {31'd0, err_unf}, 32'd1);
    chk("t4_unf_hold", out_pc, 32'h200);
    idle(); err_clr = 1;
    step();
    chk("t4_clr", {30'd0, err_ovf, err_unf}, 32'd0);

    // T5: same-cycle combinations
    load(32'h500, 32'hDDDD_0004);
    idle(); flush = 1; int_save = 1;
    step();
    chk("t5_flush_save_cnt", {30'd0, save_cnt}, 32'd0);
    chk("t5_flush_save_bub", {31'd0, out_valid}, 32'd0);
    load(32'h500, 32'hDDDD_0004);
    idle(); int_save = 1; int_restore = 1;
    step();
    chk("t5_save_rest_cnt", {30'd0, save_cnt}, 32'd1);
    chk("t5_save_rest_bub", {31'd0, out_valid}, 32'd0);
    load(32'h600, 32'hEEEE_0005); do_save();
    idle(); int_save = 1; err_clr = 1;
    step();
    chk("t5_clr_vs_ovf", {31'd0, err_ovf}, 32'd1);
    idle(); stall = 1; err_clr = 1;
    step();
    chk("t5_clr_only", {31'd0, err_ovf}, 32'd0);
    idle(); stall = 1; int_restore = 1;
    step();
    chk("t5_rest_over_stall", out_pc, 32'h600);
    do_restore();
    chk("t5_rest_D", out_inst, 32'hDDDD_0004);

    // T6: asynchronous reset mid-cycle
    load(32'h700, 32'h7777_0007); do_save();
    load(32'h800, 32'h8888_0008); do_save();
    load(32'h900, 32'h9999_0009);
    chk("t6_pre_cnt", {30'd0, save_cnt}, 32'd2);
    #3 reset_n = 0;
    #1;
    chk("t6_async_cnt", {30'd0, save_cnt}, 32'd0);
    chk("t6_async_valid", {31'd0, out_valid}, 32'd0);
    #1 reset_n = 1;
    do_restore();
    chk("t6_unf", {31'd0, err_unf}, 32'd1);
    chk("t6_unf_cnt", {30'd0, save_cnt}, 32'd0);
    chk("t6_unf_hold", {31'd0, out_valid} | out_pc, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
